io_write_port_buffer: RTL and testbench
=======================================

// Module: io_write_port_buffer
// PURPOSE
//  Per-port write buffering and readiness control for the I/O write ports.
//  - Accepts the already-predicated I/O write enable and data from the pipeline.
//  - Queues each word in a per-port FIFO and drains it over a valid/ready handshake.
//  - Generates the registered EmptyFull status (1 = not ready) that the write predication samples.
//  - Reserves slack so that writes already in flight when a port turns full are never lost.
// PARAMETERS
//  WORD_WIDTH       36  data word width
//  PORT_COUNT       4   number of I/O write ports
//  PORT_SEL_WIDTH   2   width of port index; 2**PORT_SEL_WIDTH >= PORT_COUNT
//  DEPTH            8   FIFO entries per port; power of 2; DEPTH >= PIPE_SLACK+1
//  PIPE_SLACK       4   cycles from EmptyFull sample to the matching wren, plus 1
// PORTS
//  clock       in   1                     sole clock; all state updates on posedge
//  reset       in   1                     synchronous, active-high
//  wren        in   1                     predicated write enable (already annulled when not IO_ready)
//  port_sel    in   PORT_SEL_WIDTH        target port index for wren
//  wdata       in   WORD_WIDTH            write data
//  EmptyFull   out  PORT_COUNT            per port: 1 = full/not ready, 0 = ready (registered)
//  out_valid   out  PORT_COUNT            per port: head word is valid
//  out_data    out  PORT_COUNT*WORD_WIDTH per port: head word, port p at [p*WORD_WIDTH +: WORD_WIDTH]
//  out_ready   in   PORT_COUNT            per port: consumer accepts the head word this cycle
//  overflow    out  PORT_COUNT            sticky: a write was dropped on a full port
//  stall_count out  PORT_COUNT*16         see CONFIGURATION
// BEHAVIOUR
//  - Reset (sync, high): all counts, pointers, overflow and stall_count -> 0; EmptyFull -> 0; out_valid -> 0.
//  - Push(p) = wren & (port_sel == p). A port_sel >= PORT_COUNT is ignored and has no side effect.
//  - Pop(p) = out_valid[p] & out_ready[p]. out_valid[p] = (count[p] != 0).
//  - out_data[p] is the storage head (registered storage, combinational read). It is X-free after reset only when valid.
//  - Count update: count_next = count + push_ok - pop. Pointers wrap modulo DEPTH.
//  - Push and pop on the same cycle:
//    - Empty port: no bypass. The word is stored; out_valid rises the next cycle.
//    - Full port: the pop frees an entry, so the push is accepted and count stays DEPTH.
//  - Push on a full port with no pop: the word is dropped and overflow[p] <= 1 until reset.
//  - EmptyFull[p] <= ((DEPTH - count_next[p]) <= PIPE_SLACK).
//    - Registered; it reflects the post-edge occupancy, so there is 1 cycle of latency from a push or pop.
//    - The slack reserves room for writes already committed past the predication check.
//  - Latency: wren -> out_valid is 1 cycle; pop -> EmptyFull deassert is 1 cycle.
//  - Ports are fully independent; one write per cycle in total; the consumers drain in parallel.
//  - Reset mid-operation discards all queued words. overflow does not flag the discarded words.
// CONFIGURATION
//  Macro IO_WRITE_STALL_COUNT_EN.
//  - Defined: stall_count[p] is a 16-bit counter.
//    - It increments each cycle with out_valid[p] & ~out_ready[p].
//    - It saturates at 16'hFFFF and clears on reset.
//  - Undefined: no counter logic is built and stall_count is tied to 0.
// TESTING
//  - Reset, then push 0x5 to port 1 -> next cycle out_valid=4'b0010 and out_data[1]=0x5.
//    - With out_ready[1]=1, out_valid[1]=0 one cycle later.
//  - DEPTH=8, PIPE_SLACK=4, out_ready=0, 4 pushes to port 0 -> EmptyFull[0]=1 the cycle after the 4th push.
//    - With 4 more pushes, count=8 and overflow=0.
//  - Port 0 full, 9th push with out_ready[0]=0 -> word dropped, overflow[0]=1, and it stays 1 until reset.
//  - Port 0 full, push 0xA with out_ready[0]=1 -> accepted, count stays 8, and 0xA emerges 8th in order.
//  - port_sel=3 with PORT_COUNT=3 -> no state change on any port.
//  - IO_WRITE_STALL_COUNT_EN: hold port 2 valid with out_ready=0 for 70000 cycles -> stall_count[2]=16'hFFFF.
//    - Without the macro, stall_count stays 0 throughout.

Source files
------------

// File: rtl/io_write_port_buffer_if.sv
// io_write_port_buffer_if
//   Bundles the pipeline-side write request, the per-port drain handshake
//   and the per-port status outputs of io_write_port_buffer.
//   master : drives wren/port_sel/wdata and out_ready; observes status and heads
//   slave  : the buffer itself
// Signals
//   wren, port_sel, wdata     predicated write request (one word per cycle total)
//   EmptyFull                 per port, registered: 1 = not ready for writes
//   out_valid/out_data        per port head word; port p at [p*WORD_WIDTH +: WORD_WIDTH]
//   out_ready                 per port consumer accept
//   overflow                  per port sticky drop flag
//   stall_count               per port 16-bit stall counter, [p*16 +: 16]
// Handshake: a head word transfers on a clock edge where out_valid[p] and
// out_ready[p] are both high; out_valid never depends on out_ready, and
// out_data[p] is stable while out_valid[p] is high and no transfer occurs.
interface io_write_port_buffer_if #(
  parameter int WORD_WIDTH     = 36,
  parameter int PORT_COUNT     = 4,
  parameter int PORT_SEL_WIDTH = 2
);
  logic                             wren;
  logic [PORT_SEL_WIDTH-1:0]        port_sel;
  logic [WORD_WIDTH-1:0]            wdata;
  logic [PORT_COUNT-1:0]            EmptyFull;
  logic [PORT_COUNT-1:0]            out_valid;
  logic [PORT_COUNT*WORD_WIDTH-1:0] out_data;
  logic [PORT_COUNT-1:0]            out_ready;
  logic [PORT_COUNT-1:0]            overflow;
  logic [PORT_COUNT*16-1:0]         stall_count;

  modport master (
    output wren, port_sel, wdata, out_ready,
    input  EmptyFull, out_valid, out_data, overflow, stall_count
  );

  modport slave (
    input  wren, port_sel, wdata, out_ready,
    output EmptyFull, out_valid, out_data, overflow, stall_count
  );
endinterface

// File: rtl/io_write_port_buffer.sv
// io_write_port_buffer
//   Per-port write FIFOs for the I/O write ports. Each predicated write is
//   queued in the FIFO of its target port and drained over a valid/ready
//   handshake. EmptyFull is a registered "not ready" status that asserts while
//   PIPE_SLACK entries or fewer remain free, so that writes already committed
//   past the predication check still find room.
// Ports
//   clock  sole clock, all state on posedge
//   reset  synchronous, active-high: clears counts, pointers, flags, counters
//   bus    io_write_port_buffer_if.slave (write request, drain handshake, status)
// Optional feature
//   IO_WRITE_STALL_COUNT_EN: when defined, each port has a saturating 16-bit
//   counter of cycles with out_valid high and out_ready low. When undefined,
//   no counter is built and stall_count is 0.
module io_write_port_buffer #(
  parameter int WORD_WIDTH     = 36,
  parameter int PORT_COUNT     = 4,
  parameter int PORT_SEL_WIDTH = 2,
  parameter int DEPTH          = 8,
  parameter int PIPE_SLACK     = 4
) (
  input logic                  clock,
  input logic                  reset,
  io_write_port_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(PIPE_SLACK);

  logic [WORD_WIDTH-1:0] mem [PORT_COUNT][DEPTH];
  logic [PTR_W-1:0]      wr_ptr [PORT_COUNT];
  logic [PTR_W-1:0]      rd_ptr [PORT_COUNT];
  logic [CNT_W-1:0]      count [PORT_COUNT];
  logic [CNT_W-1:0]      count_next [PORT_COUNT];

  logic [PORT_COUNT-1:0] push, pop, push_ok, drop, valid;
  logic [PORT_COUNT-1:0] empty_full_q, overflow_q;
  logic [PORT_COUNT*WORD_WIDTH-1:0] out_data_c;
  logic [PORT_COUNT*16-1:0]         stall_c;

  // A port_sel beyond PORT_COUNT-1 matches no port, so it is simply ignored.
  // A push on a full port still succeeds when the same edge pops the head.
  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      valid[p]      = (count[p] != '0);
      push[p]       = bus.wren && (bus.port_sel == PORT_SEL_WIDTH'(p));
      pop[p]        = valid[p] && bus.out_ready[p];
      push_ok[p]    = push[p] && ((count[p] != DEPTH_C) || pop[p]);
      drop[p]       = push[p] && !push_ok[p];
      count_next[p] = count[p] + CNT_W'(push_ok[p]) - CNT_W'(pop[p]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        count[p]  <= '0;
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
      empty_full_q <= '0;
      overflow_q   <= '0;
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        count[p] <= count_next[p];
        if (push_ok[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
        if (pop[p])     rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
        // Status follows post-edge occupancy: not ready once free space <= slack.
        empty_full_q[p] <= ((DEPTH_C - count_next[p]) <= SLACK_C);
        if (drop[p]) overflow_q[p] <= 1'b1;
      end
    end
  end

  // Storage carries no reset; entries are only observed while counted valid.
  always_ff @(posedge clock) begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (push_ok[p]) mem[p][wr_ptr[p]] <= bus.wdata;
    end
  end

  always_comb begin
    out_data_c = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      out_data_c[p*WORD_WIDTH +: WORD_WIDTH] = mem[p][rd_ptr[p]];
    end
  end

`ifdef IO_WRITE_STALL_COUNT_EN
  logic [15:0] stall_q [PORT_COUNT];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < PORT_COUNT; p++) stall_q[p] <= '0;
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (valid[p] && !bus.out_ready[p] && (stall_q[p] != 16'hFFFF))
          stall_q[p] <= stall_q[p] + 16'd1;
      end
    end
  end

  always_comb begin
    stall_c = '0;
    for (int p = 0; p < PORT_COUNT; p++) stall_c[p*16 +: 16] = stall_q[p];
  end
`else
  assign stall_c = '0;
`endif

  assign bus.out_valid   = valid;
  assign bus.out_data    = out_data_c;
  assign bus.EmptyFull   = empty_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.stall_count = stall_c;
endmodule

// File: tb/tb_io_write_port_buffer.sv
module tb_io_write_port_buffer;
  localparam int W  = 36;
  localparam int PC = 4;
  localparam int SW = 2;
  localparam int D  = 8;
  localparam int PS = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  io_write_port_buffer_if #(.WORD_WIDTH(W), .PORT_COUNT(PC), .PORT_SEL_WIDTH(SW)) bus ();
  io_write_port_buffer #(
    .WORD_WIDTH(W), .PORT_COUNT(PC), .PORT_SEL_WIDTH(SW), .DEPTH(D), .PIPE_SLACK(PS)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Three-port instance for the out-of-range port_sel case.
  io_write_port_buffer_if #(.WORD_WIDTH(W), .PORT_COUNT(3), .PORT_SEL_WIDTH(SW)) bus3 ();
  io_write_port_buffer #(
    .WORD_WIDTH(W), .PORT_COUNT(3), .PORT_SEL_WIDTH(SW), .DEPTH(D), .PIPE_SLACK(PS)
  ) u_dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3.slave)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] head(input int p);
    return bus.out_data[p*W +: W];
  endfunction

  task automatic chk_stall_idle(input string name);
`ifndef IO_WRITE_STALL_COUNT_EN
    chk(name, 64'(bus.stall_count), 64'h0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    bus.wren = 1'b0; bus.port_sel = '0; bus.wdata = '0; bus.out_ready = '0;
    bus3.wren = 1'b0; bus3.port_sel = '0; bus3.wdata = '0; bus3.out_ready = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Apply one cycle of inputs, sample 1 time unit after the edge.
  task automatic step(input logic we, input logic [SW-1:0] sel, input logic [W-1:0] d,
                      input logic [PC-1:0] rdy);
    bus.wren = we; bus.port_sel = sel; bus.wdata = d; bus.out_ready = rdy;
    @(posedge clock); #1;
    bus.wren = 1'b0; bus.out_ready = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [W-1:0]  d;
    logic [PC-1:0] rdy;
    logic [PC-1:0] e_valid;
    logic [PC-1:0] e_ef;
    logic [SW-1:0] cport;
    logic [W-1:0]  e_data;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    int rem;
    vecs[0] = '{1'b1, 2'd1, 36'h5,  4'b0000, 4'b0010, 4'b0000, 2'd1, 36'h5};
    vecs[1] = '{1'b0, 2'd0, 36'h0,  4'b0010, 4'b0000, 4'b0000, 2'd1, 36'h0};
    vecs[2] = '{1'b1, 2'd2, 36'h11, 4'b0100, 4'b0100, 4'b0000, 2'd2, 36'h11};
    vecs[3] = '{1'b1, 2'd2, 36'h22, 4'b0100, 4'b0100, 4'b0000, 2'd2, 36'h22};
    vecs[4] = '{1'b0, 2'd0, 36'h0,  4'b0000, 4'b0100, 4'b0000, 2'd2, 36'h22};
    vecs[5] = '{1'b0, 2'd0, 36'h0,  4'b0100, 4'b0000, 4'b0000, 2'd2, 36'h0};
    vecs[6] = '{1'b1, 2'd3, 36'h33, 4'b0000, 4'b1000, 4'b0000, 2'd3, 36'h33};
    vecs[7] = '{1'b1, 2'd0, 36'h44, 4'b1000, 4'b0001, 4'b0000, 2'd0, 36'h44};
    vecs[8] = '{1'b0, 2'd0, 36'h0,  4'b0001, 4'b0000, 4'b0000, 2'd0, 36'h0};

    do_reset();
    chk("reset valid", 64'(bus.out_valid), 64'h0);
    chk("reset ef", 64'(bus.EmptyFull), 64'h0);
    chk("reset ovf", 64'(bus.overflow), 64'h0);
    chk("reset stall", 64'(bus.stall_count), 64'h0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].we, vecs[i].sel, vecs[i].d, vecs[i].rdy);
      chk($sformatf("vec%0d valid", i), 64'(bus.out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d ef", i), 64'(bus.EmptyFull), 64'(vecs[i].e_ef));
      chk($sformatf("vec%0d ovf", i), 64'(bus.overflow), 64'h0);
      if (vecs[i].e_valid[vecs[i].cport])
        chk($sformatf("vec%0d data", i), 64'(head(int'(vecs[i].cport))), 64'(vecs[i].e_data));
    end
    chk_stall_idle("table stall");

    // ---------------- fill port 0 to full ----------------
    do_reset();
    for (int i = 0; i < D; i++) begin
      step(1'b1, 2'd0, W'(36'h100 + i), 4'b0000);
      exp_q.push_back(W'(36'h100 + i));
      chk($sformatf("fill%0d ef", i), 64'(bus.EmptyFull[0]), 64'(i >= 3));
      chk($sformatf("fill%0d ovf", i), 64'(bus.overflow), 64'h0);
      chk($sformatf("fill%0d valid", i), 64'(bus.out_valid), 64'h1);
    end

    // 9th push with no pop is dropped and flagged.
    step(1'b1, 2'd0, 36'h999, 4'b0000);
    chk("drop ovf", 64'(bus.overflow), 64'h1);
    chk("drop ef", 64'(bus.EmptyFull), 64'h1);
    step(1'b0, 2'd0, 36'h0, 4'b0000);
    chk("ovf sticky", 64'(bus.overflow), 64'h1);

    // Push while full with a simultaneous pop is accepted.
    chk("full head", 64'(head(0)), 64'(exp_q[0]));
    step(1'b1, 2'd0, 36'hA, 4'b0001);
    void'(exp_q.pop_front());
    exp_q.push_back(36'hA);
    chk("full push+pop ef", 64'(bus.EmptyFull), 64'h1);
    chk("full push+pop ovf", 64'(bus.overflow), 64'h1);

    // Drain: eight words in order, 0xA last; EmptyFull clears once 5 entries free.
    for (int k = 0; k < D; k++) begin
      chk($sformatf("drain%0d data", k), 64'(head(0)), 64'(exp_q[0]));
      step(1'b0, 2'd0, 36'h0, 4'b0001);
      void'(exp_q.pop_front());
      rem = D - 1 - k;
      chk($sformatf("drain%0d ef", k), 64'(bus.EmptyFull[0]), 64'(rem >= 4));
      chk($sformatf("drain%0d ovf", k), 64'(bus.overflow[0]), 64'h1);
    end
    chk("drained valid", 64'(bus.out_valid), 64'h0);
    chk_stall_idle("fill stall");

    // ---------------- reset mid-operation ----------------
    step(1'b1, 2'd3, 36'h7, 4'b0000);
    step(1'b1, 2'd3, 36'h8, 4'b0000);
    chk("pre-reset valid", 64'(bus.out_valid), 64'h8);
    do_reset();
    chk("midreset valid", 64'(bus.out_valid), 64'h0);
    chk("midreset ovf", 64'(bus.overflow), 64'h0);
    chk("midreset ef", 64'(bus.EmptyFull), 64'h0);

    // ---------------- out-of-range port_sel on 3-port instance ----------------
    bus3.wren = 1'b1; bus3.port_sel = 2'd0; bus3.wdata = 36'h7;
    @(posedge clock); #1;
    bus3.port_sel = 2'd3; bus3.wdata = 36'h3F;
    @(posedge clock); #1;
    bus3.wren = 1'b0;
    chk("sel3 valid", 64'(bus3.out_valid), 64'h1);
    chk("sel3 ef", 64'(bus3.EmptyFull), 64'h0);
    chk("sel3 ovf", 64'(bus3.overflow), 64'h0);
    chk("sel3 head0", 64'(bus3.out_data[0 +: W]), 64'h7);
    bus3.out_ready = 3'b001;
    @(posedge clock); #1;
    bus3.out_ready = 3'b000;
    chk("sel3 drained", 64'(bus3.out_valid), 64'h0);

    // ---------------- stall counter ----------------
    do_reset();
    step(1'b1, 2'd2, 36'h55, 4'b0000);
`ifdef IO_WRITE_STALL_COUNT_EN
    repeat (10) @(posedge clock);
    #1;
    chk("stall 10", 64'(bus.stall_count[2*16 +: 16]), 64'd10);
    repeat (70000) @(posedge clock);
    #1;
    chk("stall sat", 64'(bus.stall_count[2*16 +: 16]), 64'hFFFF);
    chk("stall other", 64'(bus.stall_count[0 +: 16]), 64'h0);
`else
    repeat (100) @(posedge clock);
    #1;
    chk("stall off", 64'(bus.stall_count), 64'h0);
`endif
    chk("stall valid", 64'(bus.out_valid), 64'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
